// File: rtl/sfx_sequencer_if.sv
// Event/piano inputs and tone-generator outputs of the sfx sequencer.
// The sequencer takes the slave side.
interface sfx_sequencer_if;
   logic       music_en;
   logic [2:0] req;
   logic [7:0] piano_key;
   logic [7:0] key_code;
   logic       busy;
   logic [1:0] active_id;
   logic       done;

   modport master (
      output music_en, req, piano_key,
      input  key_code, busy, active_id, done
   );

   modport slave (
      input  music_en, req, piano_key,
      output key_code, busy, active_id, done
   );
endinterface

// File: rtl/sfx_sequencer.sv
// Sound-effect scheduler: plays ROM note sequences for game events
// and falls back to the piano keys when idle.
module sfx_sequencer #(
   parameter int TICK_DIV = 2_500_000
) (
   input logic            clk,
   input logic            rst_n,
   sfx_sequencer_if.slave bus
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

   typedef enum logic {IDLE, PLAY} state_t;

   typedef struct packed {
      logic       last;
      logic [3:0] dur;
      logic [7:0] code;
   } step_t;

   state_t        state, state_nx;
   logic [2:0]    pend, pend_nx;
   logic [2:0]    req_eff, busy_mask, id_mask;
   logic [3:0]    idx, idx_nx;
   logic [3:0]    tick, tick_nx;
   logic [PW-1:0] presc, presc_nx;
   logic [3:0]    dur_q, dur_nx;
   logic          last_q, last_nx;
   logic [7:0]    key_q, key_nx;
   logic          busy_q, busy_nx;
   logic [1:0]    act_q, act_nx;
   logic          done_q, done_nx;
   logic          launch, step_end;
   logic [1:0]    launch_id;
   logic [3:0]    rom_addr;
   step_t         ent;

   function automatic step_t rom(input logic [3:0] i);
      case (i)
         4'd0:    rom = '{1'b0, 4'd2, 8'hfe};
         4'd1:    rom = '{1'b1, 4'd2, 8'hfb};
         4'd2:    rom = '{1'b0, 4'd1, 8'hef};
         4'd3:    rom = '{1'b0, 4'd1, 8'h7f};
         4'd4:    rom = '{1'b1, 4'd2, 8'h77};
         4'd5:    rom = '{1'b0, 4'd4, 8'h7f};
         4'd6:    rom = '{1'b0, 4'd4, 8'hbf};
         4'd7:    rom = '{1'b0, 4'd4, 8'hef};
         4'd8:    rom = '{1'b1, 4'd8, 8'hfe};
         default: rom = '{1'b1, 4'd1, 8'hff};
      endcase
   endfunction

   function automatic logic [3:0] start_of(input logic [1:0] id);
      unique case (id)
         2'd1:    start_of = 4'd2;
         2'd2:    start_of = 4'd5;
         default: start_of = 4'd0;
      endcase
   endfunction

   // One ROM read port: either a sequence start or the following step.
   always_comb begin
      launch_id = pend[2] ? 2'd2 : (pend[1] ? 2'd1 : 2'd0);
      id_mask   = 3'(3'b001 << launch_id);
      busy_mask = busy_q ? 3'(3'b001 << act_q) : 3'b000;
      req_eff   = bus.music_en ? (bus.req & ~busy_mask) : 3'b000;
      launch    = bus.music_en &&
                  ((state == IDLE) ? (|pend)
                                   : (pend[2] && act_q != 2'd2));
      step_end  = (state == PLAY) && (presc == PMAX) &&
                  ((tick + 4'd1) == dur_q);
      rom_addr  = launch ? start_of(launch_id) : idx + 4'd1;
      ent       = rom(rom_addr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         pend   <= '0;
         idx    <= '0;
         tick   <= '0;
         presc  <= '0;
         dur_q  <= '0;
         last_q <= 1'b0;
         key_q  <= 8'hff;
         busy_q <= 1'b0;
         act_q  <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         pend   <= pend_nx;
         idx    <= idx_nx;
         tick   <= tick_nx;
         presc  <= presc_nx;
         dur_q  <= dur_nx;
         last_q <= last_nx;
         key_q  <= key_nx;
         busy_q <= busy_nx;
         act_q  <= act_nx;
         done_q <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (!bus.music_en)
         state_nx = IDLE;
      else if (launch)
         state_nx = PLAY;
      else if (step_end && last_q)
         state_nx = IDLE;
   end

   always_comb begin
      pend_nx  = pend | req_eff;
      idx_nx   = idx;
      tick_nx  = tick;
      presc_nx = presc;
      dur_nx   = dur_q;
      last_nx  = last_q;
      key_nx   = key_q;
      busy_nx  = busy_q;
      act_nx   = act_q;
      done_nx  = 1'b0;
      if (!bus.music_en) begin
         pend_nx  = '0;
         idx_nx   = '0;
         tick_nx  = '0;
         presc_nx = '0;
         key_nx   = 8'hff;
         busy_nx  = 1'b0;
         act_nx   = '0;
      end else if (launch || (step_end && !last_q)) begin
         // Preemption and normal step advance share the load path.
         if (launch) begin
            pend_nx = pend_nx & ~id_mask;
            busy_nx = 1'b1;
            act_nx  = launch_id;
         end
         idx_nx   = rom_addr;
         tick_nx  = '0;
         presc_nx = '0;
         dur_nx   = ent.dur;
         last_nx  = ent.last;
         key_nx   = ent.code;
      end else if (state == IDLE) begin
         key_nx = bus.piano_key;
      end else if (step_end) begin
         tick_nx  = '0;
         presc_nx = '0;
         key_nx   = bus.piano_key;
         busy_nx  = 1'b0;
         act_nx   = '0;
         done_nx  = 1'b1;
      end else if (presc == PMAX) begin
         presc_nx = '0;
         tick_nx  = tick + 4'd1;
      end else begin
         presc_nx = presc + 1'b1;
      end
   end

   assign bus.key_code  = key_q;
   assign bus.busy      = busy_q;
   assign bus.active_id = act_q;
   assign bus.done      = done_q;
endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Sound-effect scheduler for the buzzer tone generator. It arbitrates between three game-event requesters and the manual piano keys, then drives the tone generator's 8-bit active-low key code. Each game event plays a fixed note sequence from an internal ROM, and each note is held for a programmed number of ticks. It sits between the game FSM / key scanner and the tone generator; its `key_code` output connects directly to the tone generator's `key` input.

## Interface
- `TICK_DIV`, default 2_500_000: clock cycles per duration tick (50 ms at 50 MHz). Benches use 4.
- `clk` input 1: system clock, 50 MHz.
- `rst_n` input 1: asynchronous, active-low reset.
- `music_en` input 1: sound enable. Low means silence, flush everything, ignore requests.
- `req[2:0]` input 3: event strobes, sampled on every edge. 0 = landing, 1 = floor passed, 2 = game over.
- `piano_key[7:0]` input 8: manual key code, active-low; 8'hff means no key.
- `key_code[7:0]` output 8: registered; to tone generator; 8'hff = silent.
- `busy` output 1: registered; high while a sequence plays.
- `active_id[1:0]` output 2: registered; ID of the playing sequence, 0 when idle.
- `done` output 1: registered; one-cycle pulse when a sequence completes normally.

## Operation
- Sequence ROM, entries listed as (key code, ticks):
  - ID0: (fe,2) (fb,2)
  - ID1: (ef,1) (7f,1) (77,2)
  - ID2: (7f,4) (bf,4) (ef,4) (fe,8)
- ROM has 9 steps total; each entry holds an 8-bit code, a 4-bit duration and a last-step flag. Each ID has a start index.
- `pend[2:0]` register: set by `req[i]` when `music_en` is high.
  - A request for the ID currently playing is ignored.
  - Cleared when that ID is launched.
  - All bits cleared when `music_en` is low.
- States:
  - IDLE:
    - `key_code` = `piano_key` if `music_en`, else 8'hff.
    - If `pend` is nonzero, select the highest set bit (2 > 1 > 0) and go to PLAY.
    - On that edge load the first step, set `busy`=1 and `active_id`, and clear the `pend` bit.
  - PLAY:
    - `key_code` = current ROM code. The tick prescaler and tick counter restart at every step start.
    - When the step has lasted duration×`TICK_DIV` cycles:
      - not the last step: advance to the next step;
      - last step: go to IDLE, pulse `done`, set `busy`=0 and `active_id`=0.
- Preemption: only ID2 preempts.
  - `req[2]` during ID0 or ID1 sets `pend[2]`.
  - On the next edge the current sequence is abandoned (no `done`) and ID2 loads at its first step.
  - The abandoned ID is not resumed or re-queued.
- `music_en` low in any state, on the next edge:
  - go to IDLE, `key_code`=8'hff, `busy`=0, `active_id`=0, `done`=0, `pend`=0.
- Arithmetic:
  - prescaler is ceil(log2(TICK_DIV)) bits and wraps at TICK_DIV-1;
  - tick counter is 4 bits and compares against the duration;
  - step index is 4 bits.

## Timing
- Reset (async, immediate): state IDLE, `key_code`=8'hff, `busy`=0, `active_id`=0, `done`=0, `pend`=0, all counters 0. Reset mid-sequence aborts silently.
- Request latency:
  - `req` sampled at edge E sets `pend` at E.
  - From IDLE, the first note appears on `key_code` after E+1.
- Step boundary: a note of d ticks occupies exactly d×`TICK_DIV` cycles; the next code appears on the following edge with no silent gap.
- Completion: `done`, `busy`↓ and return to piano/silence all occur on the same edge. If `pend` is nonzero, the next sequence starts one edge later, so IDLE lasts exactly one cycle.
- Simultaneous requests: all set `pend` on the same edge and are served in priority order, back to back.
- `piano_key` is ignored while `busy` is high.

## Test plan
- Landing request (`TICK_DIV`=4): one-cycle `req`=001 with `piano_key`=ff.
  - `key_code` = fe for 8 cycles, then fb for 8 cycles, then ff.
  - `done` pulses once; `busy` is high for 16 cycles.
- Simultaneous requests: `req`=111 for one cycle.
  - ID2 plays first (80 cycles), then ID1 (16 cycles), then ID0 (16 cycles).
  - Each sequence gives one `done` pulse and is followed by one IDLE cycle.
  - `active_id` steps 2 → 1 → 0.
- Preemption: `req[2]` pulsed during the second step of ID1 (code 7f).
  - Next edge: `key_code`=7f (ID2 step 0), `active_id`=2, no `done` for ID1.
  - ID1 does not replay afterwards.
- Non-preemption: `req[1]` during ID0.
  - ID0 completes; ID1 starts one cycle after ID0's `done`.
  - `req[0]` during ID0 is ignored: no replay.
- Enable drop: `music_en` falls mid-ID2 with `pend[0]` set.
  - Next edge: `key_code`=ff, `busy`=0, and no playback after `music_en` rises again.
  - `req` pulses issued while `music_en` is low are ignored.
- Piano and reset:
  - Idle with `piano_key`=ef gives `key_code`=ef the next cycle.
  - `rst_n` low mid-ID2 gives `key_code`=ff, `busy`=0 immediately with no clock edge.
  - After release, `req`=001 plays ID0 normally.
